// File: rtl/hazard_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_controller_pkg
// Description : Shared constants for the pipeline hazard controller:
//               register-specifier width, forwarding select codes, memory-wait
//               FSM state encodings and a forwarding select helper.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_controller_pkg;

    localparam int C_REG_ADDR_W = 5;

    // E-stage ALU operand select codes
    localparam logic [1:0] C_FWD_REG = 2'b00;  // register file
    localparam logic [1:0] C_FWD_MEM = 2'b10;  // ALUOutM
    localparam logic [1:0] C_FWD_WB  = 2'b01;  // ResultW

    // Memory-wait FSM encodings
    localparam int         C_STATE_W     = 2;
    localparam logic [1:0] C_ST_RUN      = 2'd0;
    localparam logic [1:0] C_ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] C_ST_FAULT    = 2'd2;

    // The younger (M) producer holds the newer value, so it wins over W.
    function automatic logic [1:0] fwdSel(input logic memHit, input logic wbHit);
        if (memHit)     return C_FWD_MEM;
        else if (wbHit) return C_FWD_WB;
        else            return C_FWD_REG;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_controller_forward_unit.sv
`default_nettype none
// ============================================================================
// Module      : forward_unit
// Description : Purely combinational forwarding compare. Register 0 never
//               matches.
// Ports       : RsD/RtD, RsE/RtE            source registers in D / E
//               WriteRegM/W, RegWriteM/W    destination + valid in M / W
//               ForwardAD/BD                D comparator operand from ALUOutM
//               ForwardAE/BE                E ALU operand select
// Revision    : 1.0 - initial release
// ============================================================================
module forward_unit
    import hazard_controller_pkg::*;
#(
    parameter int REG_ADDR_W = C_REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] RsD,
    input  logic [REG_ADDR_W-1:0] RtD,
    input  logic [REG_ADDR_W-1:0] RsE,
    input  logic [REG_ADDR_W-1:0] RtE,
    input  logic [REG_ADDR_W-1:0] WriteRegM,
    input  logic [REG_ADDR_W-1:0] WriteRegW,
    input  logic                  RegWriteM,
    input  logic                  RegWriteW,
    output logic                  ForwardAD,
    output logic                  ForwardBD,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE
);

    logic w_hitAM, w_hitAW, w_hitBM, w_hitBW;

    assign ForwardAD = (RsD != '0) && (RsD == WriteRegM) && RegWriteM;
    assign ForwardBD = (RtD != '0) && (RtD == WriteRegM) && RegWriteM;

    assign w_hitAM = (RsE != '0) && (RsE == WriteRegM) && RegWriteM;
    assign w_hitAW = (RsE != '0) && (RsE == WriteRegW) && RegWriteW;
    assign w_hitBM = (RtE != '0) && (RtE == WriteRegM) && RegWriteM;
    assign w_hitBW = (RtE != '0) && (RtE == WriteRegW) && RegWriteW;

    assign ForwardAE = fwdSel(w_hitAM, w_hitAW);
    assign ForwardBE = fwdSel(w_hitBM, w_hitBW);

endmodule
`default_nettype wire

// File: rtl/hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : hazard_controller
// Description : Pipeline sequencer for the 5-stage MIPS core. Drives the
//               forwarding selects and all stage stalls/flushes (load-use,
//               branch-compare, taken-branch squash), freezes the pipe while
//               data memory is busy, faults on memory timeout, and keeps
//               saturating stall / taken-branch debug counters.
// Ports       : clk, reset (sync, active-high)
//               RsD/RtD/RsE/RtE, WriteRegE/M/W, RegWriteE/M/W, MemtoRegE/M,
//               BranchD, PCSrcD, MemReqM, MemReadyM            -> inputs
//               ForwardAD/BD/AE/BE, StallF/D/E/M, FlushD/E/W,
//               MemFault, StallCount, BranchCount              -> outputs
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int REG_ADDR_W  = C_REG_ADDR_W,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] RsD,
    input  logic [REG_ADDR_W-1:0] RtD,
    input  logic [REG_ADDR_W-1:0] RsE,
    input  logic [REG_ADDR_W-1:0] RtE,
    input  logic [REG_ADDR_W-1:0] WriteRegE,
    input  logic [REG_ADDR_W-1:0] WriteRegM,
    input  logic [REG_ADDR_W-1:0] WriteRegW,
    input  logic                  RegWriteE,
    input  logic                  RegWriteM,
    input  logic                  RegWriteW,
    input  logic                  MemtoRegE,
    input  logic                  MemtoRegM,
    input  logic                  BranchD,
    input  logic                  PCSrcD,
    input  logic                  MemReqM,
    input  logic                  MemReadyM,
    output logic                  ForwardAD,
    output logic                  ForwardBD,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  StallE,
    output logic                  StallM,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic                  FlushW,
    output logic                  MemFault,
    output logic [CNT_W-1:0]      StallCount,
    output logic [CNT_W-1:0]      BranchCount
);

    localparam int                c_WCNT_W    = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [c_WCNT_W-1:0] c_WCNT_LAST = c_WCNT_W'(MEM_TIMEOUT - 1);
    localparam logic [c_WCNT_W-1:0] c_WCNT_ONE  = c_WCNT_W'(1);

    logic [C_STATE_W-1:0] r_state, w_stateNext;
    logic [c_WCNT_W-1:0]  r_wcnt, w_wcntNext;
    logic [CNT_W-1:0]     r_stallCount, r_branchCount;
    logic                 w_fwdAD, w_fwdBD;
    logic [1:0]           w_fwdAE, w_fwdBE;
    logic                 w_memStall, w_lwStall, w_brStall;

    forward_unit #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_forward_unit (
        .RsD       (RsD),
        .RtD       (RtD),
        .RsE       (RsE),
        .RtE       (RtE),
        .WriteRegM (WriteRegM),
        .WriteRegW (WriteRegW),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .ForwardAD (w_fwdAD),
        .ForwardBD (w_fwdBD),
        .ForwardAE (w_fwdAE),
        .ForwardBE (w_fwdBE)
    );

    // ---------------- memory-wait FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= C_ST_RUN;
            r_wcnt  <= '0;
        end else begin
            r_state <= w_stateNext;
            r_wcnt  <= w_wcntNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_wcntNext  = r_wcnt;
        case (r_state)
            C_ST_RUN: begin
                // A same-cycle ready completes the access without any wait.
                if (MemReqM && !MemReadyM) begin
                    w_stateNext = C_ST_MEM_WAIT;
                    w_wcntNext  = c_WCNT_ONE;
                end
            end
            C_ST_MEM_WAIT: begin
                if (MemReadyM) begin
                    w_stateNext = C_ST_RUN;
                    w_wcntNext  = '0;
                end else if (r_wcnt == c_WCNT_LAST) begin
                    w_stateNext = C_ST_FAULT;
                end else begin
                    w_wcntNext = r_wcnt + c_WCNT_ONE;
                end
            end
            C_ST_FAULT: w_stateNext = C_ST_FAULT;
            default:    w_stateNext = C_ST_RUN;
        endcase
    end

    // ---------------- hazard detection ----------------
    assign w_memStall = ((r_state == C_ST_RUN) && MemReqM && !MemReadyM)
                      || ((r_state == C_ST_MEM_WAIT) && !MemReadyM)
                      || (r_state == C_ST_FAULT);

    assign w_lwStall = MemtoRegE && ((RtE == RsD) || (RtE == RtD));

    assign w_brStall = BranchD && ((RegWriteE && ((WriteRegE == RsD) || (WriteRegE == RtD)))
                                || (MemtoRegM && ((WriteRegM == RsD) || (WriteRegM == RtD))));

    // ---------------- stall / flush / forward outputs ----------------
    always_comb begin
        ForwardAD = 1'b0;
        ForwardBD = 1'b0;
        ForwardAE = C_FWD_REG;
        ForwardBE = C_FWD_REG;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        if (reset) begin
            // Bubble the whole pipe while reset is held.
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
        end else begin
            ForwardAD = w_fwdAD;
            ForwardBD = w_fwdBD;
            ForwardAE = w_fwdAE;
            ForwardBE = w_fwdBE;
            if (w_memStall) begin
                // Whole pipe frozen; W gets a bubble so nothing retires twice.
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else if (w_lwStall || w_brStall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
            // A taken branch is only acted on once D is free to advance.
            FlushD = PCSrcD && !StallD;
        end
    end

    // ---------------- debug counters ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stallCount  <= '0;
            r_branchCount <= '0;
        end else begin
            if (StallF && (r_stallCount != '1))
                r_stallCount <= r_stallCount + 1'b1;
            if (FlushD && (r_branchCount != '1))
                r_branchCount <= r_branchCount + 1'b1;
        end
    end

    assign MemFault    = (r_state == C_ST_FAULT);
    assign StallCount  = r_stallCount;
    assign BranchCount = r_branchCount;

endmodule
`default_nettype wire

// File: tb/tb_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_controller
// Description : Self-checking bench for hazard_controller: a behavioural
//               reference model compared every cycle, plus literal checks of
//               the directed scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_controller;

    localparam int RA  = 5;
    localparam int TMO = 6;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [RA-1:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic          RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
    logic          BranchD, PCSrcD, MemReqM, MemReadyM;
    logic          ForwardAD, ForwardBD;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemFault;
    logic [CW-1:0] StallCount, BranchCount;

    hazard_controller #(.REG_ADDR_W(RA), .MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
        .BranchD(BranchD), .PCSrcD(PCSrcD), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .MemFault(MemFault), .StallCount(StallCount), .BranchCount(BranchCount)
    );

    always #5 clk = ~clk;

    int nVec = 0;
    int nMis = 0;
    bit chkEn = 1'b0;

    // ---------------- reference model ----------------
    // Memory side modelled as "number of consecutive stalled busy cycles so far".
    int mBusy  = 0;
    bit mFault = 1'b0;
    int mStall = 0;
    int mBranch = 0;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct packed {
        logic       fad, fbd;
        logic [1:0] fae, fbe;
        logic [6:0] ctl;   // StallF StallD StallE StallM FlushD FlushE FlushW
    } exp_t;

    function automatic logic [1:0] fwdE(input logic [RA-1:0] r);
        if (r != 0 && r == WriteRegM && RegWriteM) return 2'b10;
        if (r != 0 && r == WriteRegW && RegWriteW) return 2'b01;
        return 2'b00;
    endfunction

    function automatic exp_t modelComb();
        exp_t e;
        bit mem, lw, br, sf, sd;
        e = '0;
        if (reset) begin
            e.ctl = 7'b0000111;
            return e;
        end
        e.fad = (RsD != 0) && (RsD == WriteRegM) && RegWriteM;
        e.fbd = (RtD != 0) && (RtD == WriteRegM) && RegWriteM;
        e.fae = fwdE(RsE);
        e.fbe = fwdE(RtE);
        mem = mFault || ((mBusy > 0) ? !MemReadyM : (MemReqM && !MemReadyM));
        lw  = MemtoRegE && (RtE == RsD || RtE == RtD);
        br  = BranchD && ((RegWriteE && (WriteRegE == RsD || WriteRegE == RtD)) ||
                          (MemtoRegM && (WriteRegM == RsD || WriteRegM == RtD)));
        if (mem) begin
            sf = 1; sd = 1;
            e.ctl = {4'b1111, 1'b0, 1'b0, 1'b1};
        end else if (lw || br) begin
            sf = 1; sd = 1;
            e.ctl = {4'b1100, 1'b0, 1'b1, 1'b0};
        end else begin
            sf = 0; sd = 0;
            e.ctl = 7'b0;
        end
        e.ctl[2] = PCSrcD && !sd;
        return e;
    endfunction

    always @(posedge clk) begin
        exp_t e;
        if (reset) begin
            mBusy = 0; mFault = 0; mStall = 0; mBranch = 0;
        end else begin
            e = modelComb();
            if (e.ctl[6] && mStall < CMAX)  mStall++;
            if (e.ctl[2] && mBranch < CMAX) mBranch++;
            if (!mFault) begin
                if (mBusy == 0) begin
                    if (MemReqM && !MemReadyM) mBusy = 1;
                end else if (MemReadyM) begin
                    mBusy = 0;
                end else begin
                    mBusy++;
                end
                if (mBusy >= TMO) mFault = 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        exp_t e, a;
        if (chkEn) begin
            e = modelComb();
            a = {ForwardAD, ForwardBD, ForwardAE, ForwardBE,
                 StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
            nVec++;
            if (a !== e || MemFault !== mFault || StallCount !== CW'(mStall)
                || BranchCount !== CW'(mBranch)) begin
                nMis++;
                $display("FAIL cycle t=%0t: got outs=%h fault=%b sc=%0d bc=%0d, expected outs=%h fault=%b sc=%0d bc=%0d",
                         $time, a, MemFault, StallCount, BranchCount, e, mFault, mStall, mBranch);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        nVec++;
        if (act != exp) begin
            nMis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        RsD = 0; RtD = 0; RsE = 0; RtE = 0;
        WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
        MemtoRegE = 0; MemtoRegM = 0; BranchD = 0; PCSrcD = 0;
        MemReqM = 0; MemReadyM = 1;
    endtask

    task automatic doReset();
        reset = 1; step(); reset = 0;
    endtask

    function automatic int ctl();
        return {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
    endfunction

    initial begin
        int lowLeft;
        clr();
        reset = 1;
        step();
        chkEn = 1;
        step();
        reset = 0;
        #2;
        chk("reset_counts", {StallCount, BranchCount, 3'(MemFault)}, 0);

        // 1 forwarding
        RsE = 3; WriteRegM = 3; RegWriteM = 1; WriteRegW = 3; RegWriteW = 1; #2;
        chk("fwdAE_mem", ForwardAE, 2'b10);
        RsE = 0; #1;
        chk("fwdAE_r0", ForwardAE, 2'b00);
        RsE = 3; RegWriteM = 0; #1;
        chk("fwdAE_wb", ForwardAE, 2'b01);
        step(); clr();

        // 2 load-use
        doReset();
        MemtoRegE = 1; RtE = 2; RsD = 2; #2;
        chk("lwstall_ctl", ctl(), 7'b1100010);
        step(); clr(); #2;
        chk("lwstall_cnt", StallCount, 1);

        // 3 branch hazard then taken branch
        BranchD = 1; RegWriteE = 1; WriteRegE = 1; RsD = 1; #2;
        chk("brstall_ctl", ctl(), 7'b1100010);
        step(); clr();
        BranchD = 1; PCSrcD = 1; #2;
        chk("branch_flushD", ctl(), 7'b0000100);
        step(); clr(); #2;
        chk("branch_cnt", BranchCount, 1);
        chk("stall_cnt2", StallCount, 2);

        // 4 memory wait of 3 cycles
        MemReqM = 1; MemReadyM = 0;
        for (int i = 0; i < 3; i++) begin
            #2; chk("memwait_ctl", ctl(), 7'b1111001);
            step();
        end
        MemReadyM = 1; #2;
        chk("memwait_done", ctl(), 7'b0000000);
        step(); clr();
        MemReqM = 1; MemReadyM = 1; #2;
        chk("same_cycle_ready", ctl(), 7'b0000000);
        step(); clr();

        // 6 priority: memstall + lwstall + taken branch
        MemReqM = 1; MemReadyM = 0; MemtoRegE = 1; RtE = 2; RsD = 2; PCSrcD = 1; #2;
        chk("prio_ctl", ctl(), 7'b1111001);
        step(); clr();

        // 5 timeout
        doReset();
        MemReqM = 1; MemReadyM = 0;
        for (int i = 1; i <= TMO; i++) begin
            step(); #1;
            chk("fault_edge", MemFault, (i == TMO) ? 1 : 0);
        end
        MemReadyM = 1; #1;
        chk("fault_stall", ctl(), 7'b1111001);
        reset = 1; #1;
        chk("reset_ctl", ctl(), 7'b0000111);
        chk("reset_fwd", {ForwardAD, ForwardBD, ForwardAE, ForwardBE}, 0);
        step(); reset = 0; clr(); #2;
        chk("fault_cleared", {StallCount, BranchCount, 3'(MemFault)}, 0);

        // random phase
        lowLeft = 0;
        for (int n = 0; n < 1500; n++) begin
            RsD = RA'($urandom_range(0, 3)); RtD = RA'($urandom_range(0, 3));
            RsE = RA'($urandom_range(0, 3)); RtE = RA'($urandom_range(0, 3));
            WriteRegE = RA'($urandom_range(0, 3));
            WriteRegM = RA'($urandom_range(0, 3));
            WriteRegW = RA'($urandom_range(0, 3));
            RegWriteE = 1'($urandom); RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
            MemtoRegE = ($urandom_range(0, 3) == 0);
            MemtoRegM = ($urandom_range(0, 3) == 0);
            BranchD   = ($urandom_range(0, 2) == 0);
            PCSrcD    = 1'($urandom);
            MemReqM   = ($urandom_range(0, 3) == 0);
            if (lowLeft == 0 && $urandom_range(0, 39) == 0) lowLeft = $urandom_range(2, TMO + 2);
            if (lowLeft > 0) begin
                MemReadyM = 0; lowLeft--;
            end else begin
                MemReadyM = ($urandom_range(0, 9) < 7);
            end
            reset = ($urandom_range(0, 79) == 0);
            step();
        end
        reset = 0;
        step();
        chkEn = 0;
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
`default_nettype wire
